// File: rtl/canbus_tx_scheduler.sv
// canbus_tx_scheduler: shares one CAN transmit core among NUM_MB mailboxes.
// Each selection picks the pending mailbox with the lowest identifier. The block drives the
// core through a start/done handshake, then holds an interframe gap. Errored attempts are
// retried per mailbox up to MAX_RETRY; lost arbitration is retried without being counted.
module canbus_tx_scheduler #(
  parameter int unsigned NUM_MB     = 4,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned MAX_RETRY  = 8,
  parameter int unsigned GAP_CYCLES = 594,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MB-1:0]              mb_req,
  input  logic [NUM_MB*11-1:0]           mb_id,
  input  logic [NUM_MB*4-1:0]            mb_dlc,
  input  logic [NUM_MB*DATA_BYTES*8-1:0] mb_data,
  output logic [NUM_MB-1:0]              mb_done,
  output logic [NUM_MB-1:0]              mb_fail,
  output logic                           core_start,
  output logic [10:0]                    core_id,
  output logic [3:0]                     core_dlc,
  output logic [DATA_BYTES*8-1:0]        core_data,
  input  logic                           core_busy,
  input  logic                           core_done,
  input  logic                           core_ok,
  input  logic                           core_arb_lost
);

  localparam int unsigned DATA_BITS = DATA_BYTES * 8;
  localparam int unsigned IDX_W     = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
  localparam int unsigned RTY_W     = $clog2(MAX_RETRY + 1);
  localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0]  DLC_MAX   = (DATA_BYTES > 15) ? 4'd15 : 4'(DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [10:0]            id_q, id_d;
  logic [3:0]             dlc_q, dlc_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   start_q, start_d;
  logic [NUM_MB-1:0]      done_q, done_d;
  logic [NUM_MB-1:0]      fail_q, fail_d;
  logic [NUM_MB-1:0]      served_q, served_d;
  logic [RTY_W-1:0]       retry_q [NUM_MB];
  logic [RTY_W-1:0]       retry_d [NUM_MB];
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [GAP_W-1:0]       gap_q, gap_d;

  logic [NUM_MB-1:0]      pending;
  logic [NUM_MB-1:0]      served_set;
  logic                   err_c;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [10:0]            sel_id;
  logic [3:0]             sel_dlc;
  logic [DATA_BITS-1:0]   sel_data;

  assign pending = mb_req & ~served_q;

  // Lowest identifier among pending mailboxes; strict compare keeps ties on the lowest index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    sel_dlc   = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (pending[i] && (!sel_found || (mb_id[11*i +: 11] < sel_id))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_id    = mb_id[11*i +: 11];
        sel_dlc   = mb_dlc[4*i +: 4];
        sel_data  = mb_data[DATA_BITS*i +: DATA_BITS];
      end
    end
  end

  // Next-state, frame sequencing and retry bookkeeping.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    id_d       = id_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    start_d    = 1'b0;
    done_d     = '0;
    fail_d     = '0;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    served_set = '0;
    err_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|pending) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          id_d    = sel_id;
          dlc_d   = (sel_dlc > DLC_MAX) ? DLC_MAX : sel_dlc;
          data_d  = sel_data;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (!core_busy) begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          state_d = S_GAP;
          gap_d   = '0;
          if (core_ok) begin
            done_d[idx_q]     = 1'b1;
            served_set[idx_q] = 1'b1;
            retry_d[idx_q]    = '0;
          end else if (!core_arb_lost) begin
            err_c = 1'b1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = S_GAP;
          gap_d   = '0;
          err_c   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (err_c) begin
          if (retry_q[idx_q] == RTY_W'(MAX_RETRY - 1)) begin
            fail_d[idx_q]     = 1'b1;
            served_set[idx_q] = 1'b1;
            retry_d[idx_q]    = '0;
          end else begin
            retry_d[idx_q] = retry_q[idx_q] + RTY_W'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else                                 gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    served_d = (served_q & mb_req) | served_set;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      id_q     <= '0;
      dlc_q    <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= '0;
      fail_q   <= '0;
      served_q <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      for (int unsigned i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      id_q     <= id_d;
      dlc_q    <= dlc_d;
      data_q   <= data_d;
      start_q  <= start_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      served_q <= served_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      retry_q  <= retry_d;
    end
  end

  assign mb_done    = done_q;
  assign mb_fail    = fail_q;
  assign core_start = start_q;
  assign core_id    = id_q;
  assign core_dlc   = dlc_q;
  assign core_data  = data_q;

endmodule

// File: tb/tb_canbus_tx_scheduler.sv
// Bench for canbus_tx_scheduler: directed scenarios, a cycle-timed behavioural model of the
// scheduler's observable outputs, and a scripted transmit-core responder.
module tb_canbus_tx_scheduler;

  localparam int NMB = 4;
  localparam int DB  = 8;
  localparam int MR  = 8;
  localparam int GAP = 20;
  localparam int TMO = 300;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   mb_req = '0;
  logic [43:0]  mb_id = '0;
  logic [15:0]  mb_dlc = '0;
  logic [255:0] mb_data = '0;
  logic [3:0]   mb_done, mb_fail;
  logic         core_start;
  logic [10:0]  core_id;
  logic [3:0]   core_dlc;
  logic [63:0]  core_data;
  logic         core_busy = 1'b0;
  logic         core_done = 1'b0;
  logic         core_ok = 1'b0;
  logic         core_arb_lost = 1'b0;

  canbus_tx_scheduler #(
    .NUM_MB(NMB), .DATA_BYTES(DB), .MAX_RETRY(MR), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .mb_req(mb_req), .mb_id(mb_id), .mb_dlc(mb_dlc), .mb_data(mb_data),
    .mb_done(mb_done), .mb_fail(mb_fail), .core_start(core_start), .core_id(core_id),
    .core_dlc(core_dlc), .core_data(core_data), .core_busy(core_busy), .core_done(core_done),
    .core_ok(core_ok), .core_arb_lost(core_arb_lost)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state: cycle count and scheduling bookkeeping
  int          cyc = 0;
  logic [3:0]  m_served = '0;
  int          m_retry [NMB];
  int          m_look = 0;
  bit          m_selnext = 0, m_starting = 0, m_inflight = 0;
  int          m_idx = 0, m_start_edge = 0;
  logic [3:0]  e_done = '0, e_fail = '0;
  logic        e_start = 1'b0;
  logic [10:0] e_id = '0;
  logic [3:0]  e_dlc = '0;
  logic [63:0] e_data = '0;

  // monitor
  int          n_start = 0;
  int          done_cnt [NMB];
  int          fail_cnt [NMB];
  int          last_done_cyc = 0;
  logic [10:0] start_ids [$];
  int          start_cycs [$];

  // scripted core responses: 0 ok, 1 arb lost, 2 error, 3 never answer
  int resp_code [64];
  int resp_wr = 0, resp_rd = 0;
  int resp_delay = 9;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock edge of the model: what the registered outputs must show after this edge.
  task automatic model_step();
    logic [3:0] pend, set, nd, nf;
    logic [3:0] d;
    int key, bkey, best;
    if (rst) begin
      cyc = 0; m_served = '0; m_look = 0;
      m_selnext = 0; m_starting = 0; m_inflight = 0; m_idx = 0; m_start_edge = 0;
      for (int i = 0; i < NMB; i++) m_retry[i] = 0;
      e_done = '0; e_fail = '0; e_start = 1'b0; e_id = '0; e_dlc = '0; e_data = '0;
      return;
    end
    cyc++;
    pend = mb_req & ~m_served;
    set = '0; nd = '0; nf = '0;
    e_start = 1'b0;
    if (m_inflight) begin
      if (core_done === 1'b1 || (cyc - m_start_edge) == TMO) begin
        if (core_done === 1'b1 && core_ok === 1'b1) begin
          nd[m_idx] = 1'b1; set[m_idx] = 1'b1; m_retry[m_idx] = 0;
        end else if (!(core_done === 1'b1 && core_arb_lost === 1'b1)) begin
          m_retry[m_idx]++;
          if (m_retry[m_idx] == MR) begin
            nf[m_idx] = 1'b1; set[m_idx] = 1'b1; m_retry[m_idx] = 0;
          end
        end
        m_inflight = 0;
        m_look = cyc + GAP + 1;
      end
    end else if (m_starting) begin
      if (core_busy == 1'b0) begin
        e_start = 1'b1; m_starting = 0; m_inflight = 1; m_start_edge = cyc;
      end
    end else if (m_selnext) begin
      m_selnext = 0;
      best = -1; bkey = 0;
      for (int i = 0; i < NMB; i++) begin
        if (pend[i]) begin
          key = int'(mb_id[11*i +: 11]) * NMB + i;
          if (best < 0 || key < bkey) begin best = i; bkey = key; end
        end
      end
      if (best >= 0) begin
        m_idx  = best;
        e_id   = mb_id[11*best +: 11];
        d      = mb_dlc[4*best +: 4];
        e_dlc  = (int'(d) > DB) ? 4'(DB) : d;
        e_data = mb_data[64*best +: 64];
        m_starting = 1;
      end else begin
        m_look = cyc + 1;
      end
    end else if (cyc >= m_look && pend != '0) begin
      m_selnext = 1;
    end
    m_served = (m_served & mb_req) | set;
    e_done = nd;
    e_fail = nf;
  endtask

  task automatic clear_mon();
    n_start = 0;
    for (int i = 0; i < NMB; i++) begin done_cnt[i] = 0; fail_cnt[i] = 0; end
    start_ids.delete();
    start_cycs.delete();
  endtask

  task automatic set_mb(input int i, input logic [10:0] id, input logic [3:0] dlc,
                        input logic [63:0] data);
    mb_id[11*i +: 11]  = id;
    mb_dlc[4*i +: 4]   = dlc;
    mb_data[64*i +: 64] = data;
  endtask

  task automatic push_resp(input int code, input int n);
    for (int k = 0; k < n; k++) begin
      resp_code[resp_wr] = code;
      resp_wr++;
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k;
    k = 0;
    while (n_start < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("start_wait_bound", 64'(n_start >= n), 64'd1);
  endtask

  // Wait for every mailbox in mask to be answered, then drop its request and let the gap drain.
  task automatic wait_served(input logic [3:0] mask, input int budget);
    int  k;
    bit  all;
    k = 0;
    all = 0;
    while (!all && k < budget) begin
      @(negedge clk);
      k++;
      all = 1;
      for (int i = 0; i < NMB; i++)
        if (mask[i] && (done_cnt[i] + fail_cnt[i]) == 0) all = 0;
    end
    chk("served_wait_bound", 64'(all), 64'd1);
    mb_req = mb_req & ~mask;
    repeat (GAP + 6) @(negedge clk);
  endtask

  int t0;

  initial begin
    for (int i = 0; i < NMB; i++) begin m_retry[i] = 0; done_cnt[i] = 0; fail_cnt[i] = 0; end
    fork
      forever begin
        @(posedge clk or posedge rst);
        model_step();
      end
      forever begin
        @(negedge clk);
        chk("mb_done", 64'(mb_done), 64'(e_done));
        chk("mb_fail", 64'(mb_fail), 64'(e_fail));
        chk("core_start", 64'(core_start), 64'(e_start));
        chk("core_id", 64'(core_id), 64'(e_id));
        chk("core_dlc", 64'(core_dlc), 64'(e_dlc));
        chk("core_data", core_data, e_data);
        chk("pulse_onehot", 64'($countones(mb_done | mb_fail) <= 1), 64'd1);
        if (core_start === 1'b1) begin
          n_start++;
          start_ids.push_back(core_id);
          start_cycs.push_back(cyc);
        end
        for (int i = 0; i < NMB; i++) begin
          if (mb_done[i] === 1'b1) begin done_cnt[i]++; last_done_cyc = cyc; end
          if (mb_fail[i] === 1'b1) fail_cnt[i]++;
        end
      end
      begin : responder
        int code;
        forever begin
          @(negedge clk);
          if (core_start === 1'b1 && rst === 1'b0) begin
            code = 0;
            if (resp_rd < resp_wr) begin code = resp_code[resp_rd]; resp_rd++; end
            if (code != 3) begin
              repeat (resp_delay) @(negedge clk);
              core_done = 1'b1;
              core_ok = (code == 0);
              core_arb_lost = (code == 1);
              @(negedge clk);
              core_done = 1'b0; core_ok = 1'b0; core_arb_lost = 1'b0;
            end
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_mb_done", 64'(mb_done), 64'd0);
    chk("rst_core_id", 64'(core_id), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single mailbox, ACK 100 clocks after start
    clear_mon();
    set_mb(0, 11'h123, 4'd2, 64'h1122_3344_5566_7788);
    resp_delay = 99;
    push_resp(0, 1);
    t0 = cyc;
    mb_req = 4'b0001;
    wait_served(4'b0001, 400);
    chk("t1_starts", 64'(n_start), 64'd1);
    if (start_ids.size() >= 1) begin
      chk("t1_id", 64'(start_ids[0]), 64'h123);
      chk("t1_latency", 64'(start_cycs[0] - t0), 64'd3);
      chk("t1_done_delay", 64'(last_done_cyc - start_cycs[0]), 64'd100);
    end
    chk("t1_done0", 64'(done_cnt[0]), 64'd1);

    // two mailboxes, lower id wins; core busy delays the first start
    clear_mon();
    set_mb(1, 11'h200, 4'd1, 64'hAAAA_0000_0000_0001);
    set_mb(2, 11'h100, 4'd8, 64'hBBBB_0000_0000_0002);
    resp_delay = 9;
    push_resp(0, 2);
    t0 = cyc;
    core_busy = 1'b1;
    mb_req = 4'b0110;
    repeat (5) @(negedge clk);
    core_busy = 1'b0;
    wait_served(4'b0110, 400);
    chk("t2_starts", 64'(n_start), 64'd2);
    if (start_ids.size() >= 2) begin
      chk("t2_first_id", 64'(start_ids[0]), 64'h100);
      chk("t2_second_id", 64'(start_ids[1]), 64'h200);
      chk("t2_busy_latency", 64'(start_cycs[0] - t0), 64'd6);
      chk("t2_spacing", 64'(start_cycs[1] - start_cycs[0]), 64'd33);
    end

    // arbitration lost while a higher-priority mailbox arrives
    clear_mon();
    set_mb(0, 11'h300, 4'd4, 64'hCCCC_DDDD_EEEE_FFFF);
    set_mb(1, 11'h050, 4'd3, 64'h0101_0202_0303_0404);
    push_resp(1, 1);
    push_resp(0, 2);
    mb_req = 4'b0001;
    wait_starts(1, 50);
    mb_req = 4'b0011;
    wait_served(4'b0011, 600);
    chk("t3_starts", 64'(n_start), 64'd3);
    if (start_ids.size() >= 3) begin
      chk("t3_id0", 64'(start_ids[0]), 64'h300);
      chk("t3_id1", 64'(start_ids[1]), 64'h050);
      chk("t3_id2", 64'(start_ids[2]), 64'h300);
    end
    chk("t3_fail_none", 64'(fail_cnt[0] + fail_cnt[1]), 64'd0);

    // every attempt errors -> MAX_RETRY starts then fail
    clear_mon();
    set_mb(3, 11'h010, 4'd4, 64'h5555_6666_7777_8888);
    resp_delay = 5;
    push_resp(2, MR);
    mb_req = 4'b1000;
    wait_served(4'b1000, 1000);
    chk("t4_starts", 64'(n_start), 64'd8);
    chk("t4_fail3", 64'(fail_cnt[3]), 64'd1);
    chk("t4_done3", 64'(done_cnt[3]), 64'd0);

    // dlc clamp and timeouts
    clear_mon();
    set_mb(2, 11'h7FF, 4'd15, 64'hDEAD_BEEF_CAFE_F00D);
    push_resp(3, MR);
    mb_req = 4'b0100;
    wait_starts(1, 50);
    chk("t5_dlc_clamp", 64'(core_dlc), 64'd8);
    wait_served(4'b0100, 4000);
    chk("t5_starts", 64'(n_start), 64'd8);
    chk("t5_fail2", 64'(fail_cnt[2]), 64'd1);
    if (start_cycs.size() >= 2)
      chk("t5_timeout_spacing", 64'(start_cycs[1] - start_cycs[0]), 64'd323);

    // reset during WAIT after three errors; retry count restarts
    clear_mon();
    set_mb(0, 11'h155, 4'd3, 64'h0F0F_0F0F_F0F0_F0F0);
    push_resp(2, 3);
    push_resp(3, 1);
    mb_req = 4'b0001;
    wait_starts(4, 400);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_start", 64'(core_start), 64'd0);
    chk("t6_rst_done", 64'(mb_done), 64'd0);
    chk("t6_rst_fail", 64'(mb_fail), 64'd0);
    chk("t6_rst_id", 64'(core_id), 64'd0);
    chk("t6_rst_dlc", 64'(core_dlc), 64'd0);
    chk("t6_rst_data", core_data, 64'd0);
    clear_mon();
    push_resp(2, MR);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_served(4'b0001, 1000);
    chk("t6_starts", 64'(n_start), 64'd8);
    chk("t6_fail0", 64'(fail_cnt[0]), 64'd1);
    chk("t6_done0", 64'(done_cnt[0]), 64'd0);

    // request dropped mid-frame still completes
    clear_mon();
    set_mb(1, 11'h0AA, 4'd5, 64'h1234_5678_9ABC_DEF0);
    resp_delay = 9;
    push_resp(0, 1);
    mb_req = 4'b0010;
    wait_starts(1, 50);
    mb_req = 4'b0000;
    wait_served(4'b0010, 200);
    chk("t7_done1", 64'(done_cnt[1]), 64'd1);
    chk("t7_starts", 64'(n_start), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
